i2c_slave_regfile: RTL and testbench

Next-generation I2C slave register file, clocked by a system clock with SCL/SDA treated as oversampled asynchronous inputs instead of as clocks. It provides a parametrised bank of 8-bit registers with a register pointer, auto-increment, repeated-START support and glitch filtering. It sits behind the board-level open-drain pad, where `top` drives SDA low whenever SDA_OE=1, and exposes the register bank to the rest of the design.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_in_filter.sv | 49 ++++
 rtl/i2c_slave_regfile.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register file.
// Contents: FSM state enum, ACK/NACK and R/W bit levels, and a
// small helper that appends one received bit to a byte (MSB first).
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // Bytes arrive MSB first, so each new bit enters at the LSB end.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_i);
    return {cur[6:0], bit_i};
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Synchroniser plus glitch filter for one oversampled bus line.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset (output presets to 1, bus idle)
//   din_i  - raw asynchronous pad level
//   dout_o - filtered level; changes only after FILT_LEN equal samples
module i2c_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic dout_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-1:0]    hist_q;
  logic                   dout_q;
  logic                   dout_d;

  // Synchroniser chain, sample history and filtered output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      hist_q <= {FILT_LEN{1'b1}};
      dout_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      hist_q <= {hist_q[FILT_LEN-2:0], sync_q[SYNC_STAGES-1]};
      dout_q <= dout_d;
    end
  end

  // Accept a new level only when the whole history window agrees.
  always_comb begin
    dout_d = dout_q;
    if (&hist_q) begin
      dout_d = 1'b1;
    end else if (~|hist_q) begin
      dout_d = 1'b0;
    end else begin
      dout_d = dout_q;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a bank of NREGS 8-bit registers. SCL/SDA are sampled
// with the system clock (no bus clocking), filtered, then edge-detected.
// Ports:
//   CLK       - system clock (>= 20x SCL)
//   RST       - asynchronous active-high reset
//   SCL_IN    - raw SCL pad level
//   SDA_IN    - raw SDA pad level
//   SDA_OE    - 1 pulls SDA low (open-drain enable)
//   REGS_OUT  - flattened register bank, reg k at [8k+7:8k]
//   WR_STROBE - one-CLK pulse per register write
//   WR_ADDR   - index written, valid with WR_STROBE
//   BUSY      - set on address match, cleared by STOP
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3,
  localparam int        PTR_W       = $clog2(NREGS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SCL_IN,
  input  logic               SDA_IN,
  output logic               SDA_OE,
  output logic [NREGS*8-1:0] REGS_OUT,
  output logic               WR_STROBE,
  output logic [PTR_W-1:0]   WR_ADDR,
  output logic               BUSY
);

  logic scl_f_s, sda_f_s;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ack_drv_q, ack_drv_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic             wr_en_s;
  logic [7:0]       rx_byte_s;
  logic [PTR_W-1:0] ptr_inc_s, ptr_mod_s;
  logic [7:0]       regs_q [NREGS];

  i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i(CLK), .rst_i(RST), .din_i(SCL_IN), .dout_o(scl_f_s)
  );

  i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i(CLK), .rst_i(RST), .din_i(SDA_IN), .dout_o(sda_f_s)
  );

  assign scl_rise_s = scl_f_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_f_s & scl_prev_q;
  // SCL must be high on both samples so an SDA change around an SCL edge
  // is never mistaken for START/STOP.
  assign start_s    = sda_prev_q & ~sda_f_s & scl_f_s & scl_prev_q;
  assign stop_s     = ~sda_prev_q & sda_f_s & scl_f_s & scl_prev_q;

  assign rx_byte_s  = shift_in(shift_q, sda_f_s);
  assign ptr_inc_s  = (ptr_q == PTR_W'(NREGS - 1)) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);
  // Widened to 9 bits so NREGS = 256 is a valid divisor.
  assign ptr_mod_s  = PTR_W'({1'b0, rx_byte_s} % 9'(NREGS));

  // Bus event handling, bit shifting and ACK/read-data drive.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    ack_drv_d = ack_drv_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_s   = 1'b0;

    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_drv_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte_s[7:1] == DEV_ADDR) begin
                    state_d = ST_ADDR_ACK;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IDLE;
                  end
                end
                ST_PTR: begin
                  ptr_d   = ptr_mod_s;
                  state_d = ST_PTR_ACK;
                end
                ST_WDATA: begin
                  wr_en_s = 1'b1;
                  state_d = ST_WDATA_ACK;
                end
                default: state_d = ST_IDLE;
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end

        // First SCL fall after the byte starts the ACK, the next ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!ack_drv_q) begin
              sda_oe_d  = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_drv_d = 1'b0;
              bit_cnt_d = 3'd0;
              case (state_q)
                ST_ADDR_ACK: begin
                  if (shift_q[0] == I2C_READ) begin
                    // First read bit goes out on this same fall.
                    state_d  = ST_RDATA;
                    sda_oe_d = ~regs_q[ptr_q][7];
                    shift_d  = {regs_q[ptr_q][6:0], 1'b0};
                  end else begin
                    state_d = ST_PTR;
                  end
                end
                ST_PTR_ACK: state_d = ST_WDATA;
                ST_WDATA_ACK: begin
                  state_d = ST_WDATA;
                  ptr_d   = ptr_inc_s;
                end
                default: state_d = ST_IDLE;
              endcase
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_RDATA_ACK;
            end else begin
              state_d = state_q;
            end
          end else if (scl_fall_s) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else begin
            state_d = state_q;
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise_s) begin
            if (sda_f_s == I2C_ACK) begin
              ptr_d     = ptr_inc_s;
              shift_d   = regs_q[ptr_inc_s];
              bit_cnt_d = 3'd0;
              state_d   = ST_RDATA;
            end else begin
              // Master NACK: BUSY is held until the STOP arrives.
              state_d = ST_IDLE;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state, edge-detect history and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= {PTR_W{1'b0}};
      ack_drv_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {PTR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ack_drv_q   <= ack_drv_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      scl_prev_q  <= scl_f_s;
      sda_prev_q  <= sda_f_s;
      wr_strobe_q <= wr_en_s;
      if (wr_en_s) begin
        wr_addr_q <= ptr_q;
      end
    end
  end

  // Register bank; only a completed 8-bit write reaches here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else if (wr_en_s) begin
      regs_q[ptr_q] <= rx_byte_s;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign REGS_OUT[8*g +: 8] = regs_q[g];
  end

  assign SDA_OE    = sda_oe_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: acts as I2C master on an open-drain bus model and
// checks writes, pointer-then-read, wrap, address mismatch, glitch
// rejection and asynchronous reset during a read.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scl_m = 1'b1, sda_m = 1'b1;
  logic         scl_g = 1'b0, sda_g = 1'b0;
  logic         scl_in, sda_in, sda_oe, wr_strobe, busy;
  logic [127:0] regs_out;
  logic [3:0]   wr_addr;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [3:0] wr_log [32];

  // Open-drain bus: master, slave and glitch injectors can only pull low.
  assign scl_in = scl_m & ~scl_g;
  assign sda_in = sda_m & ~sda_oe & ~sda_g;

  i2c_slave_regfile dut (
    .CLK(clk), .RST(rst), .SCL_IN(scl_in), .SDA_IN(sda_in), .SDA_OE(sda_oe),
    .REGS_OUT(regs_out), .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Record strobes and activity counters away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (wr_cnt < 32) wr_log[wr_cnt] = wr_addr;
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; wait_clk(20);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_clk(10);
    scl_m = 1'b1; wait_clk(20);
    sda_m = 1'b0; wait_clk(20);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(10);
    scl_m = 1'b1; wait_clk(20);
    sda_m = 1'b1; wait_clk(20);
  endtask

  // Optional glitch: 1-CLK low pulses on SDA then SCL while SCL is high.
  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; wait_clk(10);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(8);
      sda_g = 1'b1; wait_clk(1); sda_g = 1'b0;
      wait_clk(4);
      scl_g = 1'b1; wait_clk(1); scl_g = 1'b0;
      wait_clk(6);
    end else begin
      wait_clk(20);
    end
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic recv_bit(output logic v);
    sda_m = 1'b1; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    v = sda_in;
    wait_clk(10);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == glitch_bit));
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(v);
      d[i] = v;
    end
    send_bit(ack_bit, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         wr0, oe0, busy0;

    // Reset state
    wait_clk(5);
    chk("rst_sda_oe", 128'(sda_oe), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_wr_strobe", 128'(wr_strobe), 128'd0);
    chk("rst_wr_addr", 128'(wr_addr), 128'd0);
    chk("rst_regs", regs_out, 128'd0);
    rst = 1'b0;
    wait_clk(10);

    // 1. Write 0xA5 to reg 3
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'h54, -1, ack); chk("t1_addr_ack", 128'(ack), 128'd0);
    write_byte(8'h03, -1, ack); chk("t1_ptr_ack", 128'(ack), 128'd0);
    write_byte(8'hA5, -1, ack); chk("t1_data_ack", 128'(ack), 128'd0);
    bus_stop();
    wait_clk(15);
    chk("t1_reg3", 128'(regs_out[31:24]), 128'hA5);
    chk("t1_wr_count", 128'(wr_cnt - wr0), 128'd1);
    chk("t1_wr_addr", 128'(wr_log[wr0]), 128'd3);
    chk("t1_busy_after_stop", 128'(busy), 128'd0);

    // 2. Pointer then read via repeated START
    bus_start();
    write_byte(8'h54, -1, ack); chk("t2_addr_ack", 128'(ack), 128'd0);
    write_byte(8'h03, -1, ack); chk("t2_ptr_ack", 128'(ack), 128'd0);
    bus_rstart();
    write_byte(8'h55, -1, ack); chk("t2_raddr_ack", 128'(ack), 128'd0);
    read_byte(rd, 1'b1);
    chk("t2_read_data", 128'(rd), 128'hA5);
    chk("t2_busy_before_stop", 128'(busy), 128'd1);
    bus_stop();
    wait_clk(15);
    chk("t2_busy_after_stop", 128'(busy), 128'd0);

    // 3. Auto-increment wrap 15 -> 0
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'h54, -1, ack); chk("t3_addr_ack", 128'(ack), 128'd0);
    write_byte(8'h0F, -1, ack); chk("t3_ptr_ack", 128'(ack), 128'd0);
    write_byte(8'h11, -1, ack); chk("t3_d0_ack", 128'(ack), 128'd0);
    write_byte(8'h22, -1, ack); chk("t3_d1_ack", 128'(ack), 128'd0);
    bus_stop();
    wait_clk(15);
    chk("t3_reg15", 128'(regs_out[127:120]), 128'h11);
    chk("t3_reg0", 128'(regs_out[7:0]), 128'h22);
    chk("t3_wr_count", 128'(wr_cnt - wr0), 128'd2);
    chk("t3_wr_addr0", 128'(wr_log[wr0]), 128'd15);
    chk("t3_wr_addr1", 128'(wr_log[wr0 + 1]), 128'd0);

    // 4. Address mismatch: bus ignored
    wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    write_byte(8'h56, -1, ack); chk("t4_addr_nack", 128'(ack), 128'd1);
    write_byte(8'h12, -1, ack);
    write_byte(8'h34, -1, ack);
    bus_stop();
    wait_clk(15);
    chk("t4_no_sda_oe", 128'(oe_cnt - oe0), 128'd0);
    chk("t4_no_strobe", 128'(wr_cnt - wr0), 128'd0);
    chk("t4_no_busy", 128'(busy_cnt - busy0), 128'd0);

    // 5. Glitches on SCL and SDA during the data byte
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'h54, -1, ack); chk("t5_addr_ack", 128'(ack), 128'd0);
    write_byte(8'h05, -1, ack); chk("t5_ptr_ack", 128'(ack), 128'd0);
    write_byte(8'hC3, 7, ack);  chk("t5_data_ack", 128'(ack), 128'd0);
    chk("t5_busy_held", 128'(busy), 128'd1);
    bus_stop();
    wait_clk(15);
    chk("t5_reg5", 128'(regs_out[47:40]), 128'hC3);
    chk("t5_wr_count", 128'(wr_cnt - wr0), 128'd1);

    // 6. Asynchronous reset while the slave drives SDA low in a read
    bus_start();
    write_byte(8'h54, -1, ack); chk("t6_addr_ack", 128'(ack), 128'd0);
    write_byte(8'h03, -1, ack); chk("t6_ptr_ack", 128'(ack), 128'd0);
    bus_rstart();
    write_byte(8'h55, -1, ack); chk("t6_raddr_ack", 128'(ack), 128'd0);
    recv_bit(ack);
    chk("t6_bit7", 128'(ack), 128'd1);
    for (int i = 0; i < 50 && !sda_oe; i++) @(negedge clk);
    chk("t6_oe_driving", 128'(sda_oe), 128'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_oe_released", 128'(sda_oe), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_regs_clear", regs_out, 128'd0);
    chk("t6_state_idle", 128'(dut.state_q), 128'(ST_IDLE));
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(10);
    rst = 1'b0;
    wait_clk(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
